// File: rtl/wb_arbiter_pkg.sv
// Shared defaults for the register-file writeback path: widths, the zero-register
// address and a saturating adder used by the optional WB_ARB_STATS_EN counters.
package wb_arbiter_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int ZERO_REG   = 0;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Multi-cycle result FIFO with per-entry live bits, address-match kill and lookup.
// WB_ARB_STATS_EN adds kill_num, the number of live entries killed this cycle.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = 4,
  localparam int IW    = $clog2(DEPTH),
  localparam int PW    = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_addr,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [AWIDTH-1:0] kill_addr,
  input  logic [AWIDTH-1:0] chk_addr,
  output logic              chk_pending,
  output logic              head_valid,
  output logic              head_live,
  output logic [AWIDTH-1:0] head_addr,
  output logic [DWIDTH-1:0] head_data,
  output logic              full,
  output logic [PW-1:0]     count
`ifdef WB_ARB_STATS_EN
  ,
  output logic [PW-1:0]     kill_num
`endif
);
  logic [DEPTH-1:0][AWIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DWIDTH-1:0] data_q;
  logic [DEPTH-1:0]             live_q, kill_hit, chk_hit, pop_mask, push_mask;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [IW-1:0]                wr_idx, rd_idx;
  logic                         empty, do_push, do_pop;

  assign wr_idx  = wr_ptr[IW-1:0];
  assign rd_idx  = rd_ptr[IW-1:0];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_idx == rd_idx);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Live bits are only ever set for occupied slots, so live implies occupied.
  always_comb begin
    kill_hit  = '0;
    chk_hit   = '0;
    pop_mask  = '0;
    push_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = kill_en && live_q[i] && (addr_q[i] == kill_addr);
      chk_hit[i]  = live_q[i] && (addr_q[i] == chk_addr);
    end
    if (do_pop)  pop_mask[rd_idx]  = 1'b1;
    if (do_push) push_mask[wr_idx] = 1'b1;
  end

  assign chk_pending = (|chk_hit) && (chk_addr != AWIDTH'(ZERO_REG));
  assign head_valid  = !empty;
  assign head_live   = live_q[rd_idx];
  assign head_addr   = addr_q[rd_idx];
  assign head_data   = data_q[rd_idx];

`ifdef WB_ARB_STATS_EN
  always_comb begin
    kill_num = '0;
    for (int i = 0; i < DEPTH; i++) kill_num = kill_num + PW'(kill_hit[i]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live_q <= '0;
    end else begin
      live_q <= (live_q & ~kill_hit & ~pop_mask) | push_mask;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_idx] <= push_addr;
      data_q[wr_idx] <= push_data;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback wins, multi-cycle results
// queue and drain in idle slots. WB_ARB_STATS_EN adds kill/drop/stall counters.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   r_clk,
  input  logic                   r_rst,
  input  logic                   wb_valid,
  input  logic [AWIDTH-1:0]      wb_addr,
  input  logic [DWIDTH-1:0]      wb_data,
  input  logic                   mc_valid,
  input  logic [AWIDTH-1:0]      mc_addr,
  input  logic [DWIDTH-1:0]      mc_data,
  output logic                   mc_ready,
  input  logic [AWIDTH-1:0]      chk_addr,
  output logic                   chk_pending,
  output logic                   r_wr_en,
  output logic [AWIDTH-1:0]      r_addr_in,
  output logic [DWIDTH-1:0]      r_data_in,
  output logic [$clog2(DEPTH):0] pending_cnt
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]            kill_cnt,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic              full, head_valid, head_live;
  logic              wb_wr, mc_acc, mc_drop, mc_push, pop;
  logic [AWIDTH-1:0] head_addr;
  logic [DWIDTH-1:0] head_data;

  assign mc_ready = !full && !r_rst;
  assign wb_wr    = wb_valid && (wb_addr != AWIDTH'(ZERO_REG));
  assign mc_acc   = mc_valid && mc_ready;
  // A same-cycle wb write to the same register is younger, so the mc result is dead on arrival.
  assign mc_drop  = mc_acc && ((mc_addr == AWIDTH'(ZERO_REG)) || (wb_wr && (mc_addr == wb_addr)));
  assign mc_push  = mc_acc && !mc_drop;
  assign pop      = !wb_wr && head_valid;

`ifdef WB_ARB_STATS_EN
  logic [PW-1:0] kill_num;
`endif

  wb_fifo #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (r_clk),
    .rst        (r_rst),
    .push       (mc_push),
    .push_addr  (mc_addr),
    .push_data  (mc_data),
    .pop        (pop),
    .kill_en    (wb_wr),
    .kill_addr  (wb_addr),
    .chk_addr   (chk_addr),
    .chk_pending(chk_pending),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .count      (pending_cnt)
`ifdef WB_ARB_STATS_EN
    ,
    .kill_num   (kill_num)
`endif
  );

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_wr_en   <= 1'b0;
      r_addr_in <= '0;
      r_data_in <= '0;
    end else if (wb_wr) begin
      r_wr_en   <= 1'b1;
      r_addr_in <= wb_addr;
      r_data_in <= wb_data;
    end else if (pop && head_live) begin
      r_wr_en   <= 1'b1;
      r_addr_in <= head_addr;
      r_data_in <= head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      kill_cnt  <= '0;
      drop_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      kill_cnt  <= sat_add16(kill_cnt, 16'(kill_num));
      drop_cnt  <= sat_add16(drop_cnt, {15'd0, mc_drop});
      stall_cnt <= sat_add16(stall_cnt, {15'd0, mc_valid && !mc_ready});
    end
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; stats outputs are checked when WB_ARB_STATS_EN is defined.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          mc_valid = 1'b0;
  logic [AW-1:0] mc_addr = '0;
  logic [DW-1:0] mc_data = '0;
  logic          mc_ready;
  logic [AW-1:0] chk_addr = '0;
  logic          chk_pending;
  logic          r_wr_en;
  logic [AW-1:0] r_addr_in;
  logic [DW-1:0] r_data_in;
  logic [2:0]    pending_cnt;
`ifdef WB_ARB_STATS_EN
  logic [15:0]   kill_cnt, drop_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .mc_valid   (mc_valid),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .chk_addr   (chk_addr),
    .chk_pending(chk_pending),
    .r_wr_en    (r_wr_en),
    .r_addr_in  (r_addr_in),
    .r_data_in  (r_data_in),
    .pending_cnt(pending_cnt)
`ifdef WB_ARB_STATS_EN
    ,
    .kill_cnt   (kill_cnt),
    .drop_cnt   (drop_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check("rst_wr_en", 64'(r_wr_en), 0);
    check("rst_addr", 64'(r_addr_in), 0);
    check("rst_data", 64'(r_data_in), 0);
    check("rst_cnt", 64'(pending_cnt), 0);
    check("rst_ready", 64'(mc_ready), 0);
    check("rst_chk", 64'(chk_pending), 0);
    r_rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(mc_ready), 1);

    // plain pipeline write
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    tick();
    wb_valid = 1'b0;
    check("wb_wr_en", 64'(r_wr_en), 1);
    check("wb_addr", 64'(r_addr_in), 3);
    check("wb_data", 64'(r_data_in), 32'h11);
    tick();
    check("wb_wr_en_off", 64'(r_wr_en), 0);
    check("wb_addr_hold", 64'(r_addr_in), 3);

    // single multi-cycle result
    mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'hAA;
    tick();
    mc_valid = 1'b0;
    check("mc_enq_wr_en", 64'(r_wr_en), 0);
    check("mc_enq_cnt", 64'(pending_cnt), 1);
    tick();
    check("mc_wr_en", 64'(r_wr_en), 1);
    check("mc_addr", 64'(r_addr_in), 7);
    check("mc_data", 64'(r_data_in), 32'hAA);
    check("mc_cnt_drained", 64'(pending_cnt), 0);
    tick();
    check("mc_wr_en_off", 64'(r_wr_en), 0);

    // fill while the pipeline owns every slot
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h100;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1'b1; mc_addr = AW'(10 + i); mc_data = DW'(32'hB0 + i);
      check($sformatf("fill_ready%0d", i), 64'(mc_ready), 1);
      tick();
    end
    mc_addr = 5'd20; mc_data = 32'hBF;
    check("full_ready", 64'(mc_ready), 0);
    check("full_cnt", 64'(pending_cnt), 4);
    check("fill_wb_wr_en", 64'(r_wr_en), 1);
    check("fill_wb_addr", 64'(r_addr_in), 1);
    tick();
    mc_valid = 1'b0;
    check("stall_cnt_hold", 64'(pending_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      chk_addr = AW'(10 + i);
      #1;
      check($sformatf("fill_chk%0d", i), 64'(chk_pending), 1);
    end
    chk_addr = 5'd20;
    #1;
    check("stall_not_queued", 64'(chk_pending), 0);
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain_wr_en%0d", i), 64'(r_wr_en), 1);
      check($sformatf("drain_addr%0d", i), 64'(r_addr_in), 64'(10 + i));
      check($sformatf("drain_data%0d", i), 64'(r_data_in), 64'(32'hB0 + i));
      check($sformatf("drain_cnt%0d", i), 64'(pending_cnt), 64'(3 - i));
    end
    tick();
    check("drain_done", 64'(r_wr_en), 0);

    // kill a queued result with a younger pipeline write
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h55;
    tick();
    mc_valid = 1'b0;
    chk_addr = 5'd9;
    #1;
    check("kill_chk_before", 64'(chk_pending), 1);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h66;
    tick();
    wb_valid = 1'b0;
    check("kill_wb_wr_en", 64'(r_wr_en), 1);
    check("kill_wb_data", 64'(r_data_in), 32'h66);
    check("kill_cnt_occupied", 64'(pending_cnt), 1);
    check("kill_chk_after", 64'(chk_pending), 0);
    tick();
    check("killed_pop_wr_en", 64'(r_wr_en), 0);
    check("killed_pop_cnt", 64'(pending_cnt), 0);
    check("killed_pop_data", 64'(r_data_in), 32'h66);

    // zero-register requests from both sources
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h88;
    mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h77;
    check("zero_ready", 64'(mc_ready), 1);
    tick();
    wb_valid = 1'b0; mc_valid = 1'b0;
    check("zero_wr_en", 64'(r_wr_en), 0);
    check("zero_cnt", 64'(pending_cnt), 0);
    tick();
    check("zero_wr_en2", 64'(r_wr_en), 0);
`ifdef WB_ARB_STATS_EN
    check("drop_cnt1", 64'(drop_cnt), 1);
    check("kill_cnt1", 64'(kill_cnt), 1);
    check("stall_cnt1", 64'(stall_cnt), 1);
`endif

    // same-cycle conflict: mc result to the register the pipeline writes
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hDEAD;
    tick();
    wb_valid = 1'b0; mc_valid = 1'b0;
    check("conf_data", 64'(r_data_in), 32'h1234);
    check("conf_cnt", 64'(pending_cnt), 0);
    tick();
    check("conf_wr_en", 64'(r_wr_en), 0);
`ifdef WB_ARB_STATS_EN
    check("drop_cnt2", 64'(drop_cnt), 2);
`endif

    // reset with entries queued
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h200;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1'b1; mc_addr = AW'(20 + i); mc_data = DW'(32'hC0 + i);
      tick();
    end
    check("mid_cnt", 64'(pending_cnt), 3);
    r_rst = 1'b1; wb_valid = 1'b0; mc_valid = 1'b0;
    #1;
    check("mid_rst_ready", 64'(mc_ready), 0);
    tick();
    chk_addr = 5'd20;
    #1;
    check("mid_rst_cnt", 64'(pending_cnt), 0);
    check("mid_rst_wr_en", 64'(r_wr_en), 0);
    check("mid_rst_chk", 64'(chk_pending), 0);
`ifdef WB_ARB_STATS_EN
    check("mid_rst_drop", 64'(drop_cnt), 0);
`endif
    r_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_wr_en%0d", i), 64'(r_wr_en), 0);
    end
    check("post_rst_cnt", 64'(pending_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
